// File: rtl/board_frame_compositor_if.sv
// Handshake and pixel bus between the game logic / matrix driver and board_frame_compositor.
interface board_frame_compositor_if #(
  parameter int WIDTH   = 16,
  parameter int HEIGHT  = 16,
  parameter int N_LANES = 4,
  parameter int ROW_W   = $clog2(HEIGHT),
  parameter int COL_W   = $clog2(WIDTH)
);
  logic                       frame_strobe;
  logic [N_LANES*ROW_W-1:0]   lane_row;
  logic [N_LANES*WIDTH-1:0]   lane_data;
  logic [ROW_W-1:0]           frog_row;
  logic [COL_W-1:0]           frog_col;
  logic [ROW_W-1:0]           win_row;
  logic                       clear_hit;
  logic [HEIGHT*WIDTH-1:0]    RedPixels;
  logic [HEIGHT*WIDTH-1:0]    GrnPixels;
  logic                       busy;
  logic                       frame_done;
  logic                       hit;
  logic                       win;

  modport master (
    output frame_strobe, lane_row, lane_data, frog_row, frog_col, win_row, clear_hit,
    input  RedPixels, GrnPixels, busy, frame_done, hit, win
  );

  modport slave (
    input  frame_strobe, lane_row, lane_data, frog_row, frog_col, win_row, clear_hit,
    output RedPixels, GrnPixels, busy, frame_done, hit, win
  );
endinterface

// File: rtl/board_frame_compositor.sv
// Registered LED-matrix frame builder: snapshot, clear, one lane per cycle, atomic publish.
// Optional frog blink while hit is set: define BOARD_BLINK_EN.
module board_frame_compositor #(
  parameter int WIDTH        = 16,
  parameter int HEIGHT       = 16,
  parameter int N_LANES      = 4,
  parameter int ROW_W        = $clog2(HEIGHT),
  parameter int COL_W        = $clog2(WIDTH),
  parameter int BLINK_CYCLES = 12500000
) (
  input logic clk,
  input logic reset,
  board_frame_compositor_if.slave bus
);
  localparam int K_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, COMPOSE, PUBLISH} state_t;

  state_t state, state_nx;
  logic [K_W-1:0]                 k;
  logic                           snap_en, clr_en, comp_en, pub_en, last_lane;
  logic [N_LANES*ROW_W-1:0]       snap_rows;
  logic [N_LANES*WIDTH-1:0]       snap_data;
  logic [ROW_W-1:0]               snap_frow, snap_wrow, cur_row;
  logic [COL_W-1:0]               snap_fcol;
  logic [WIDTH-1:0]               cur_data;
  logic [HEIGHT-1:0][WIDTH-1:0]   shadow_red, shadow_grn, grn_final;
  logic                           frow_ok, fcol_ok, frog_ok, coll, win_nx, frog_vis;

  assign last_lane = (k == K_W'(N_LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.frame_strobe) state_nx = CLEAR;
      CLEAR:   state_nx = COMPOSE;
      COMPOSE: if (last_lane) state_nx = PUBLISH;
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    snap_en = (state == IDLE) && bus.frame_strobe;
    clr_en  = (state == CLEAR);
    comp_en = (state == COMPOSE);
    pub_en  = (state == PUBLISH);
  end

  // Snapshot registers are pure data and only read after a snapshot has been taken
  always_ff @(posedge clk) begin
    if (snap_en) begin
      snap_rows <= bus.lane_row;
      snap_data <= bus.lane_data;
      snap_frow <= bus.frog_row;
      snap_fcol <= bus.frog_col;
      snap_wrow <= bus.win_row;
    end
  end

  always_comb begin
    cur_row  = '0;
    cur_data = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (k == K_W'(i)) begin
        cur_row  = snap_rows[i*ROW_W +: ROW_W];
        cur_data = snap_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Range checks by enumeration so narrow index fields never produce constant compares
  always_comb begin
    frow_ok = 1'b0;
    fcol_ok = 1'b0;
    for (int r = 0; r < HEIGHT; r++) if (snap_frow == ROW_W'(r)) frow_ok = 1'b1;
    for (int c = 0; c < WIDTH; c++)  if (snap_fcol == COL_W'(c)) fcol_ok = 1'b1;
  end

  assign frog_ok = frow_ok && fcol_ok;
  assign coll    = frog_ok && (cur_row == snap_frow) && |(cur_data & (WIDTH'(1) << snap_fcol));
  assign win_nx  = frog_ok && (snap_frow == snap_wrow);

`ifdef BOARD_BLINK_EN
  localparam int BC_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BC_W-1:0] blink_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!bus.hit) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BC_W'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign frog_vis = !bus.hit || !blink_phase;
`else
  assign frog_vis = 1'b1;
`endif

  always_comb begin
    grn_final = shadow_grn;
    for (int r = 0; r < HEIGHT; r++) begin
      if (frog_ok && (snap_frow == ROW_W'(r))) begin
        if (frog_vis) grn_final[r] = grn_final[r] | (WIDTH'(1) << snap_fcol);
        if (win_nx)   grn_final[r] = '1;
      end
    end
  end

  // Shadow buffers: cleared, then one lane OR-merged per COMPOSE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_red <= '0;
      shadow_grn <= '0;
      k          <= '0;
    end else if (clr_en) begin
      shadow_red <= '0;
      shadow_grn <= '0;
      k          <= '0;
    end else if (comp_en) begin
      for (int r = 0; r < HEIGHT; r++)
        if (cur_row == ROW_W'(r)) shadow_red[r] <= shadow_red[r] | cur_data;
      k <= k + 1'b1;
    end else if (pub_en) begin
      shadow_grn <= grn_final;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.RedPixels  <= '0;
      bus.GrnPixels  <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.hit        <= 1'b0;
      bus.win        <= 1'b0;
    end else begin
      bus.frame_done <= pub_en;
      if (snap_en)     bus.busy <= 1'b1;
      else if (pub_en) bus.busy <= 1'b0;
      if (pub_en) begin
        bus.RedPixels <= shadow_red;
        bus.GrnPixels <= grn_final;
        bus.win       <= win_nx;
      end
      // A collision in the same cycle as clear_hit keeps the flag set
      if (comp_en && coll)    bus.hit <= 1'b1;
      else if (bus.clear_hit) bus.hit <= 1'b0;
    end
  end
endmodule

// File: tb/tb_board_frame_compositor.sv
// Directed and randomized frame checks of board_frame_compositor against a plane-level model.
module tb_board_frame_compositor;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int NL = 4;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int PW = H * W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   model_hit = 1'b0;

  always #5 clk = ~clk;

  board_frame_compositor_if #(.WIDTH(W), .HEIGHT(H), .N_LANES(NL), .ROW_W(RW), .COL_W(CW)) bus ();

  board_frame_compositor #(.WIDTH(W), .HEIGHT(H), .N_LANES(NL), .ROW_W(RW), .COL_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [NL*RW-1:0] rows, input logic [NL*W-1:0] data,
                           input logic [RW-1:0] frow, input logic [CW-1:0] fcol,
                           input logic [RW-1:0] wrow, input bit poke, input int clr_until);
    logic [PW-1:0] er, eg;
    bit coll[NL];
    bit fok, ewin, set;
    int r, cyc, extra;
    er  = '0;
    eg  = '0;
    fok = (int'(frow) < H) && (int'(fcol) < W);
    for (int i = 0; i < NL; i++) begin
      r = int'(rows[i*RW +: RW]);
      if (r < H) er[r*W +: W] = er[r*W +: W] | data[i*W +: W];
      coll[i] = fok && (r == int'(frow)) && data[i*W + int'(fcol)];
    end
    ewin = fok && (frow == wrow);
    if (fok) begin
      eg[int'(frow)*W + int'(fcol)] = 1'b1;
      if (ewin) eg[int'(wrow)*W +: W] = '1;
    end
    // lane i is composed on the edge 2+i after the accepted strobe
    for (int e = 0; e <= NL + 2; e++) begin
      set = 1'b0;
      if (e >= 2 && e < NL + 2) set = coll[e-2];
      if (set) model_hit = 1'b1;
      else if (e <= clr_until) model_hit = 1'b0;
    end

    @(negedge clk);
    bus.lane_row = rows;  bus.lane_data = data;
    bus.frog_row = frow;  bus.frog_col = fcol;  bus.win_row = wrow;
    bus.frame_strobe = 1'b1;
    bus.clear_hit = (clr_until >= 0);
    @(negedge clk);
    bus.frame_strobe = 1'b0;
    cyc = 0;
    check("busy_start", PW'(bus.busy), PW'(1));
    while (bus.frame_done !== 1'b1 && cyc < 20) begin
      bus.clear_hit = (cyc + 1 <= clr_until);
      if (poke && cyc == 1) begin
        bus.frame_strobe = 1'b1;
        bus.lane_data = {$urandom, $urandom};
        bus.frog_row = RW'($urandom_range(0, 15));
      end
      if (poke && cyc == 2) bus.frame_strobe = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.clear_hit = 1'b0;
    bus.frame_strobe = 1'b0;
    check("latency", PW'(cyc), PW'(NL + 2));
    check("red", bus.RedPixels, er);
    check("grn", bus.GrnPixels, eg);
    check("hit", PW'(bus.hit), PW'(model_hit));
    check("win", PW'(bus.win), PW'(ewin));
    check("busy_end", PW'(bus.busy), PW'(0));
    @(negedge clk);
    check("done_pulse", PW'(bus.frame_done), PW'(0));
    if (poke) begin
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.frame_done === 1'b1) extra++;
      end
      check("no_extra_frame", PW'(extra), PW'(0));
      check("red_hold", bus.RedPixels, er);
      check("grn_hold", bus.GrnPixels, eg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*RW-1:0] rows;
    logic [NL*W-1:0]  data;
    logic [RW-1:0]    frow, wrow;
    logic [CW-1:0]    fcol;
    int               clr;

    bus.frame_strobe = 1'b0; bus.clear_hit = 1'b0;
    bus.lane_row = '0; bus.lane_data = '0;
    bus.frog_row = '0; bus.frog_col = '0; bus.win_row = '0;
    repeat (3) @(negedge clk);
    check("rst_red", bus.RedPixels, '0);
    check("rst_grn", bus.GrnPixels, '0);
    check("rst_busy", PW'(bus.busy), '0);
    check("rst_done", PW'(bus.frame_done), '0);
    check("rst_hit", PW'(bus.hit), '0);
    check("rst_win", PW'(bus.win), '0);
    reset = 1'b1;

    run_frame({5'd6, 5'd5, 5'd3, 5'd1}, {4{16'h0100}}, 5'd0, 5'd3, 5'd15, 1'b0, -1);
    run_frame({5'd10, 5'd12, 5'd3, 5'd3}, {16'h0000, 16'h0000, 16'h0010, 16'h0001},
              5'd3, 5'd4, 5'd15, 1'b0, -1);
    repeat (5) @(negedge clk);
    check("hit_sticky", PW'(bus.hit), PW'(1));

    run_frame({5'd16, 5'd2, 5'd4, 5'd8}, {16'hFFFF, 16'h00F0, 16'h0F00, 16'hF000},
              5'd2, 5'd20, 5'd2, 1'b1, -1);

    bus.clear_hit = 1'b1;
    @(negedge clk);
    bus.clear_hit = 1'b0;
    model_hit = 1'b0;
    check("hit_clear", PW'(bus.hit), PW'(0));

    run_frame({5'd9, 5'd7, 5'd5, 5'd3}, {4{16'h8001}}, 5'd15, 5'd7, 5'd15, 1'b0, -1);
    run_frame({5'd9, 5'd7, 5'd5, 5'd3}, {4{16'h8001}}, 5'd14, 5'd7, 5'd15, 1'b0, -1);
    run_frame({5'd2, 5'd11, 5'd12, 5'd13}, {16'h0020, 16'h0000, 16'h0000, 16'h0000},
              5'd2, 5'd5, 5'd9, 1'b0, NL + 1);

    // asynchronous reset while lanes are being composed
    @(negedge clk);
    bus.lane_row = {5'd1, 5'd2, 5'd3, 5'd4}; bus.lane_data = {4{16'hAAAA}};
    bus.frog_row = 5'd1; bus.frog_col = 5'd1; bus.frame_strobe = 1'b1;
    @(negedge clk);
    bus.frame_strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    model_hit = 1'b0;
    check("arst_red", bus.RedPixels, '0);
    check("arst_grn", bus.GrnPixels, '0);
    check("arst_busy", PW'(bus.busy), '0);
    check("arst_hit", PW'(bus.hit), '0);
    check("arst_win", PW'(bus.win), '0);
    @(negedge clk);
    reset = 1'b1;
    run_frame({5'd6, 5'd5, 5'd3, 5'd1}, {4{16'h0100}}, 5'd0, 5'd3, 5'd15, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      frow = RW'($urandom_range(0, 17));
      fcol = CW'($urandom_range(0, 17));
      wrow = ($urandom_range(0, 1) == 1) ? frow : RW'($urandom_range(0, 16));
      for (int i = 0; i < NL; i++) begin
        rows[i*RW +: RW] = ($urandom_range(0, 2) == 0) ? frow : RW'($urandom_range(0, 17));
        data[i*W +: W]   = W'($urandom);
      end
      clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_frame(rows, data, frow, fcol, wrow, 1'($urandom_range(0, 1)), clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_frame_compositor.md
Name: board_frame_compositor

Overview:
Parametrised, registered frame builder for the LED-matrix playfield. Snapshots N_LANES car-lane bit patterns plus the frog position on a frame strobe. Composes them into shadow red/green buffers one lane per cycle, checks frog/car collision and the win row, then publishes both buffers atomically to the matrix driver. Replaces the fixed four-lane, row-hardwired combinational display with configurable lane-to-row mapping and glitch-free frame updates.

Parameters:
WIDTH, 16, matrix columns; lane/row vector width; column c maps to bit c.
HEIGHT, 16, matrix rows.
N_LANES, 4, number of car lanes composited per frame.
ROW_W, $clog2(HEIGHT), width of row indices.
COL_W, $clog2(WIDTH), width of column indices.
BLINK_CYCLES, 12500000, clocks per blink half-period; used only with BOARD_BLINK_EN.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low: asserted when 0.
frame_strobe  in  1  one-cycle request to build a frame from the current inputs.
lane_row  in  N_LANES*ROW_W  target row of each lane; lane i occupies [i*ROW_W +: ROW_W].
lane_data  in  N_LANES*WIDTH  car pattern of each lane; lane i occupies [i*WIDTH +: WIDTH].
frog_row  in  ROW_W  frog row.
frog_col  in  COL_W  frog column.
win_row  in  ROW_W  goal row.
clear_hit  in  1  clears the sticky hit flag.
RedPixels  out  HEIGHT*WIDTH  published red plane; row r occupies [r*WIDTH +: WIDTH].
GrnPixels  out  HEIGHT*WIDTH  published green plane, same layout.
busy  out  1  high while a frame is being composed.
frame_done  out  1  one-cycle pulse when new planes are published.
hit  out  1  sticky frog/car collision flag.
win  out  1  registered: the last published frame had frog_row == win_row.

Behaviour:
- Reset (reset=0, asynchronous): RedPixels=0, GrnPixels=0, shadow buffers=0, busy=0, frame_done=0, hit=0, win=0, FSM=IDLE, blink counter=0, blink phase=0.
- FSM has four states: IDLE, CLEAR, COMPOSE, PUBLISH.
- IDLE: on frame_strobe, snapshot all lane, frog and win inputs into registers, set busy=1, and go to CLEAR.
- CLEAR: zero both shadow buffers, set lane index k=0, and go to COMPOSE.
- COMPOSE: one lane per cycle. If lane_row[k] < HEIGHT, OR lane_data[k] into shadow red row lane_row[k]; otherwise skip the lane silently. After lane k = N_LANES-1, go to PUBLISH.
- Lanes mapped to the same row are OR-merged.
- Collision: set hit if any in-range lane has lane_row == frog_row and lane_data bit frog_col = 1. The check is evaluated during COMPOSE.
- PUBLISH, frog placement: if frog_row < HEIGHT and frog_col < WIDTH, set shadow green bit (frog_row, frog_col). Otherwise draw no frog and do no collision or win check.
- PUBLISH, win: if the frog is in range and frog_row == win_row, fill the whole shadow green row win_row with ones and set win=1; otherwise win=0.
- PUBLISH, output: copy the shadow buffers to RedPixels/GrnPixels in one edge, pulse frame_done, clear busy, and return to IDLE.
- Latency: strobe sampled at edge 0 gives outputs and frame_done valid after edge N_LANES+2. Outputs hold steady between publishes and never show a partial frame.
- A collision pixel is both red and green (amber).
- frame_strobe while busy=1 is ignored; no queueing.
- hit stays set until clear_hit=1. If clear_hit and a new collision happen in the same cycle, the set wins.
- win_row is drawn only when the frog reaches it.

Optional Feature:
- Macro: BOARD_BLINK_EN.
- Defined:
  - While hit=1, the frog pixel is gated by a blink phase. The phase toggles every BLINK_CYCLES clocks.
  - The counter and phase are held at 0 while hit=0.
  - The phase is sampled at PUBLISH, so the frog is visible on even phases.
  - Red car pixels are unaffected.
- Not defined: the frog pixel is always drawn. No counter logic is synthesised.

Test Plan:
- Reset: pulse reset=0 mid-COMPOSE -> all outputs 0 immediately, FSM in IDLE; the next strobe builds a clean frame.
- Basic frame: lane rows {1,3,5,6}, every lane data 16'h0100, frog (0,3), strobe -> frame_done exactly 6 cycles later; red rows 1,3,5,6 = 16'h0100; green row 0 = 16'h0008; hit=0.
- Collision and merge: lanes 0 and 1 both on row 3 with data 16'h0001 and 16'h0010, frog (3,4) -> red row 3 = 16'h0011, green row 3 = 16'h0010, hit=1. Hit stays 1 until clear_hit.
- Out-of-range and busy: lane_row=16 for one lane and frog_col beyond WIDTH -> lane ignored, no frog drawn, hit unchanged. A second strobe issued while busy produces no extra frame_done.
- Win: win_row=15, frog (15,7) -> green row 15 = 16'hFFFF, win=1. The next frame with frog at row 14 gives win=0.
- Blink (BOARD_BLINK_EN, BLINK_CYCLES=4): hit=1, strobe every cycle frame_done allows -> frog pixel alternates present/absent per phase. clear_hit=1 -> frog steady.
